// File: rtl/sbox_engine.sv
// Multi-lane byte-substitution engine: loadable forward table with a shadow inverse table,
// two-stage valid/ready pipeline (input register, lookup result register).
module sbox_engine #(
    parameter int unsigned LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    input  logic               cfg_we,
    input  logic [7:0]         cfg_addr,
    input  logic [7:0]         cfg_data,
    output logic               cfg_ready,
    output logic               busy
);
    localparam int unsigned W = 8 * LANES;

    logic [7:0]   fwd_q [256];
    logic [7:0]   fwd_d [256];
    logic [7:0]   inv_q [256];
    logic [7:0]   inv_d [256];

    logic         s1_valid_q, s1_valid_d;
    logic         s1_inv_q, s1_inv_d;
    logic [W-1:0] s1_data_q, s1_data_d;
    logic         s2_valid_q, s2_valid_d;
    logic [W-1:0] s2_data_q, s2_data_d;

    logic [W-1:0] lookup;
    logic         s2_load;
    logic         in_acc;
    logic         cfg_acc;

    always_comb begin
        s2_load   = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready  = !s1_valid_q || s2_load;
        in_acc    = in_valid && in_ready;
        busy      = s1_valid_q || s2_valid_q;
        // Writes only land on an empty, idle pipeline, so no beat sees a half-updated table.
        cfg_ready = !busy && !in_valid;
        cfg_acc   = cfg_we && cfg_ready;
        out_valid = s2_valid_q;
        out_data  = s2_data_q;
    end

    always_comb begin
        fwd_d = fwd_q;
        inv_d = inv_q;
        if (cfg_acc) begin
            fwd_d[cfg_addr] = cfg_data;
            inv_d[cfg_data] = cfg_addr;
        end
    end

    always_comb begin
        lookup = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            lookup[8*k +: 8] = s1_inv_q ? inv_q[s1_data_q[8*k +: 8]]
                                        : fwd_q[s1_data_q[8*k +: 8]];
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_inv_d   = s1_inv_q;
        s1_data_d  = s1_data_q;
        if (in_acc) begin
            s1_valid_d = 1'b1;
            s1_inv_d   = in_inv;
            s1_data_d  = in_data;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_data_d  = lookup;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) begin
                fwd_q[i] <= 8'(i);
                inv_q[i] <= 8'(i);
            end
            s1_valid_q <= 1'b0;
            s1_inv_q   <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            fwd_q      <= fwd_d;
            inv_q      <= inv_d;
            s1_valid_q <= s1_valid_d;
            s1_inv_q   <= s1_inv_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

endmodule

// File: tb/tb_sbox_engine.sv
// Bench for sbox_engine: table/queue reference model checked every cycle, plus literal pins.
module tb_sbox_engine;
    localparam int unsigned LANES = 4;
    localparam int W = 8 * LANES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_inv = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b1;
    logic         cfg_we = 1'b0;
    logic [7:0]   cfg_addr = '0;
    logic [7:0]   cfg_data = '0;
    logic         in_ready, out_valid, cfg_ready, busy;
    logic [W-1:0] out_data;

    int checks = 0;
    int errors = 0;

    sbox_engine #(.LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: plain tables plus a queue of expected output beats.
    logic [7:0]   m_fwd [256];
    logic [7:0]   m_inv [256];
    logic [W-1:0] exp_q [$];
    int           pop_cyc [$];
    logic [W-1:0] last_out = '0;
    int           pops = 0;
    int           cyc = 0;
    bit           acc_last = 0;
    bit           prev_stall = 0;
    logic [W-1:0] prev_data = '0;
    bit           rand_or = 0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_sub(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        for (int k = 0; k < LANES; k++)
            r[8*k +: 8] = inv ? m_inv[d[8*k +: 8]] : m_fwd[d[8*k +: 8]];
        return r;
    endfunction

    task automatic model_identity();
        for (int a = 0; a < 256; a++) begin
            m_fwd[a] = 8'(a);
            m_inv[a] = 8'(a);
        end
    endtask

    initial model_identity();

    always @(negedge clk) begin
        int  n;
        bit  exp_ov;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            model_identity();
            acc_last   = 0;
            prev_stall = 0;
        end else begin
            n = exp_q.size();
            exp_ov = (n == 2) || (n == 1 && !acc_last);
            chk("in_ready", in_ready, (n < 2) || out_ready);
            chk("out_valid", out_valid, exp_ov);
            chk("busy", busy, n > 0);
            chk("cfg_ready", cfg_ready, (n == 0) && !in_valid);
            if (prev_stall) chk("stall_hold", out_data, prev_data);
            if (exp_ov && out_ready) begin
                chk("out_data", out_data, exp_q[0]);
                last_out = out_data;
                void'(exp_q.pop_front());
                pop_cyc.push_back(cyc);
                pops++;
            end
            if (cfg_we && cfg_ready) begin
                m_fwd[cfg_addr] = cfg_data;
                m_inv[cfg_data] = cfg_addr;
            end
            acc_last = in_valid && in_ready;
            if (acc_last) exp_q.push_back(model_sub(in_data, in_inv));
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_or) out_ready = 1'($urandom_range(0, 1));
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [W-1:0] d, input logic inv);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
        bit ok = 0;
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = cfg_ready;
            @(posedge clk);
            #1;
        end
        cfg_we = 1'b0;
        if (!ok) chk("cfg_timeout", 0, 1);
    endtask

    task automatic wait_pop(input int p0, input string name, input logic [W-1:0] exp);
        for (int i = 0; i < 200 && pops <= p0; i++) begin
            @(posedge clk);
            #1;
        end
        chk({name, "_arrived"}, pops > p0, 1);
        chk(name, last_out, exp);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_q.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    logic [7:0] perm [256];
    int p0, c0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Identity after reset, both directions.
        p0 = pops; send(32'h5300FFA7, 1'b0); wait_pop(p0, "ident_fwd", 32'h5300FFA7);
        p0 = pops; send(32'h5300FFA7, 1'b1); wait_pop(p0, "ident_inv", 32'h5300FFA7);

        // Random permutation with four pinned entries.
        for (int a = 0; a < 256; a++) perm[a] = 8'(a);
        for (int a = 255; a > 0; a--) begin
            int j;
            logic [7:0] t;
            j = $urandom_range(0, a);
            t = perm[a]; perm[a] = perm[j]; perm[j] = t;
        end
        begin
            logic [7:0] pa [4];
            logic [7:0] pv [4];
            pa = '{8'h00, 8'h01, 8'h02, 8'h45};
            pv = '{8'h93, 8'hD9, 8'h9A, 8'h00};
            for (int e = 0; e < 4; e++) begin
                for (int j = 0; j < 256; j++) begin
                    if (perm[j] == pv[e]) begin
                        perm[j] = perm[pa[e]];
                        perm[pa[e]] = pv[e];
                        break;
                    end
                end
            end
        end
        for (int a = 0; a < 256; a++) cfg_write(8'(a), perm[a]);
        p0 = pops; send(32'h45020100, 1'b0); wait_pop(p0, "load_fwd", 32'h009AD993);
        p0 = pops; send(32'h009AD993, 1'b1); wait_pop(p0, "load_inv", 32'h45020100);

        // Back-to-back alternating modes.
        p0 = pops;
        c0 = cyc;
        for (int i = 0; i < 16; i++) send(W'($urandom), 1'(i));
        chk("b2b_cycles", cyc - c0, 16);
        drain();
        chk("b2b_count", pops - p0, 16);
        chk("b2b_consecutive", pop_cyc[p0 + 15] - pop_cyc[p0], 15);

        // Backpressure.
        p0 = pops;
        out_ready = 1'b0;
        send(32'h11111111, 1'b0);
        send(32'h22222222, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h33333333;
        in_inv   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(32'h33333333, 1'b0);
        drain();
        chk("bp_count", pops - p0, 3);
        chk("bp_last", last_out, model_sub(32'h33333333, 1'b0));

        // Random traffic with random backpressure and permutation-preserving swaps.
        rand_or = 1;
        for (int i = 0; i < 300; i++) begin
            send(W'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            if (i % 60 == 59) begin
                logic [7:0] a, b, va, vb;
                a = 8'($urandom);
                b = 8'($urandom);
                va = m_fwd[a];
                vb = m_fwd[b];
                cfg_write(a, vb);
                cfg_write(b, va);
            end
        end
        rand_or = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        chk("rand_model_perm", model_sub(model_sub(32'hC0FFEE01, 1'b0), 1'b1), 32'hC0FFEE01);

        // Write interlock: the held-off write must not affect the beat in flight.
        begin
            logic [7:0] old10;
            old10 = m_fwd[8'h10];
            send(32'h10101010, 1'b0);
            cfg_we = 1'b1; cfg_addr = 8'h10; cfg_data = 8'h77;
            @(negedge clk);
            chk("il_busy", busy, 1);
            chk("il_cfg_ready", cfg_ready, 0);
            @(posedge clk);
            #1;
            cfg_write(8'h10, 8'h77);
            chk("il_old_value", last_out, {4{old10}});
            p0 = pops; send(32'h00000010, 1'b0);
            wait_pop(p0, "il_new_value", {m_fwd[8'h00], m_fwd[8'h00], m_fwd[8'h00], 8'h77});
        end

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(32'hAAAAAAAA, 1'b0);
        send(32'hBBBBBBBB, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_out_valid", out_valid, 0);
            @(posedge clk);
            #1;
        end
        p0 = pops; send(32'h00000000, 1'b0); wait_pop(p0, "rst_mid_zero", 32'h00000000);
        p0 = pops; send(32'h45020110, 1'b0); wait_pop(p0, "rst_mid_ident", 32'h45020110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
